// File: rtl/if_id_reg_pkg.sv
// Shared constants and payload type for the IF/ID pipeline register.
package if_id_reg_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  // ExcCode values used by the pipeline
  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  // Default text segment bounds and exception handler entry
  localparam logic [XLEN-1:0] TEXT_BASE_DEF  = 32'h0000_3000;
  localparam logic [XLEN-1:0] TEXT_TOP_DEF   = 32'h0000_6FFC;
  localparam logic [XLEN-1:0] HANDLER_PC_DEF = 32'h0000_4180;

  // Contents of the D stage register
  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [EXC_W-1:0] exc;
    logic             bd;
    logic             valid;
  } id_stage_t;

endpackage

// File: rtl/if_id_reg_if.sv
// F-to-D bus: pipeline control, fetched instruction in, D-stage state out.
interface if_id_reg_if;
  import if_id_reg_pkg::*;

  logic             stall;
  logic             req;
  logic             eret_clr;
  logic             is_bj_d;
  logic [XLEN-1:0]  pc_f;
  logic [XLEN-1:0]  instr_f;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  instr_d;
  logic [EXC_W-1:0] exc_d;
  logic             bd_d;
  logic             valid_d;

  // Pipeline side: drives F inputs and control, observes D stage
  modport master (
    output stall, req, eret_clr, is_bj_d, pc_f, instr_f,
    input  pc_d, instr_d, exc_d, bd_d, valid_d
  );

  // Register side
  modport slave (
    input  stall, req, eret_clr, is_bj_d, pc_f, instr_f,
    output pc_d, instr_d, exc_d, bd_d, valid_d
  );

endinterface

// File: rtl/if_id_reg_fetch_addr_chk.sv
// Fetch address check: flags a misaligned or out-of-text-segment PC (AdEL).
module fetch_addr_chk
  import if_id_reg_pkg::*;
#(
  parameter logic [XLEN-1:0] TEXT_BASE = TEXT_BASE_DEF,
  parameter logic [XLEN-1:0] TEXT_TOP  = TEXT_TOP_DEF
) (
  input  logic [XLEN-1:0] pc,
  output logic            adel
);

  // Unsigned compares; both bounds are themselves legal addresses
  always_comb begin
    adel = (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || (pc > TEXT_TOP);
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush, stall, ERET kill and fetch-fault tagging.
// Build option: define IF_ID_FETCH_EXC_EN to enable the fetch address check
// (AdEL on misaligned or out-of-text PC); otherwise exc_d is always 0.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter logic [XLEN-1:0] TEXT_BASE  = TEXT_BASE_DEF,
  parameter logic [XLEN-1:0] TEXT_TOP   = TEXT_TOP_DEF,
  parameter logic [XLEN-1:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input logic        clk,
  input logic        reset,
  if_id_reg_if.slave bus
);

  localparam id_stage_t RESET_VAL = '{pc: TEXT_BASE, instr: '0, exc: EXC_NONE,
                                      bd: 1'b0, valid: 1'b0};

  id_stage_t stage_q;
  id_stage_t stage_d;
  logic      fetch_exc;

`ifdef IF_ID_FETCH_EXC_EN
  logic adel;

  fetch_addr_chk #(
    .TEXT_BASE (TEXT_BASE),
    .TEXT_TOP  (TEXT_TOP)
  ) u_fetch_addr_chk (
    .pc   (bus.pc_f),
    .adel (adel)
  );

  assign fetch_exc = adel;
`else
  assign fetch_exc = 1'b0;
`endif

  // Next D-stage contents: req > stall > eret_clr > load
  always_comb begin
    stage_d = stage_q;
    if (bus.req) begin
      stage_d = '{pc: HANDLER_PC, instr: '0, exc: EXC_NONE, bd: 1'b0, valid: 1'b0};
    end else if (bus.stall) begin
      stage_d = stage_q;
    end else if (bus.eret_clr) begin
      stage_d = '{pc: bus.pc_f, instr: '0, exc: EXC_NONE, bd: 1'b0, valid: 1'b0};
    end else begin
      stage_d.pc    = bus.pc_f;
      stage_d.bd    = bus.is_bj_d;
      stage_d.valid = 1'b1;
      if (fetch_exc) begin
        // Faulting word is squashed so it never decodes; bd kept for EPC
        stage_d.exc   = EXC_ADEL;
        stage_d.instr = '0;
      end else begin
        stage_d.exc   = EXC_NONE;
        stage_d.instr = bus.instr_f;
      end
    end
  end

  // D-stage register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= RESET_VAL;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.pc_d    = stage_q.pc;
  assign bus.instr_d = stage_q.instr;
  assign bus.exc_d   = stage_q.exc;
  assign bus.bd_d    = stage_q.bd;
  assign bus.valid_d = stage_q.valid;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed vector table plus random cycles
// against a behavioural model, results matched through a scoreboard queue.
module tb_if_id_reg;
  import if_id_reg_pkg::*;

`ifdef IF_ID_FETCH_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        stall;
    logic        req;
    logic        eret;
    logic        bj;
    logic [31:0] pc;
    logic [31:0] instr;
    id_stage_t   exp;
  } vec_t;

  localparam int unsigned NVEC = 20;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  id_stage_t sb_q[$];
  vec_t      vecs[NVEC];
  id_stage_t mdl;

  if_id_reg_if bus ();

  if_id_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic id_stage_t st(input logic [31:0] pc, input logic [31:0] instr,
                                   input logic [4:0] exc, input logic bd, input logic v);
    id_stage_t s;
    s.pc = pc; s.instr = instr; s.exc = exc; s.bd = bd; s.valid = v;
    return s;
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic q, input logic e,
                              input logic bj, input logic [31:0] pc, input logic [31:0] ins,
                              input id_stage_t exp);
    vec_t v;
    v.rst = r; v.stall = s; v.req = q; v.eret = e; v.bj = bj;
    v.pc = pc; v.instr = ins; v.exp = exp;
    return v;
  endfunction

  // Behavioural reference for one clock edge
  function automatic id_stage_t model(input id_stage_t cur, input vec_t v);
    id_stage_t n;
    logic bad;
    bad = EXC_ON && ((v.pc % 4) != 0 || v.pc < 32'h3000 || v.pc > 32'h6FFC);
    if (v.rst)        n = st(32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
    else if (v.req)   n = st(32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
    else if (v.stall) n = cur;
    else if (v.eret)  n = st(v.pc, 32'h0, 5'd0, 1'b0, 1'b0);
    else if (bad)     n = st(v.pc, 32'h0, 5'd4, v.bj, 1'b1);
    else              n = st(v.pc, v.instr, 5'd0, v.bj, 1'b1);
    return n;
  endfunction

  task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drive one cycle of stimulus, push its expectation, then check the D stage
  task automatic apply(input vec_t v, input string tag);
    id_stage_t e;
    @(negedge clk);
    reset        = v.rst;
    bus.stall    = v.stall;
    bus.req      = v.req;
    bus.eret_clr = v.eret;
    bus.is_bj_d  = v.bj;
    bus.pc_f     = v.pc;
    bus.instr_f  = v.instr;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    cmp32({tag, ".pc_d"},    bus.pc_d,    e.pc);
    cmp32({tag, ".instr_d"}, bus.instr_d, e.instr);
    cmp32({tag, ".exc_d"},   32'(bus.exc_d), 32'(e.exc));
    cmp32({tag, ".bd_d"},    32'(bus.bd_d),  32'(e.bd));
    cmp32({tag, ".valid_d"}, 32'(bus.valid_d), 32'(e.valid));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    id_stage_t rst_s, held;
    reset = 1'b1;
    bus.stall = 1'b0; bus.req = 1'b0; bus.eret_clr = 1'b0; bus.is_bj_d = 1'b0;
    bus.pc_f = 32'h0; bus.instr_f = 32'h0;

    rst_s = st(32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
    held  = st(32'h3004, 32'h2401_0001, 5'd0, 1'b1, 1'b1);
    vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0000_3004, 32'h1234_5678, rst_s);
    vecs[1]  = mk(0, 0, 0, 0, 1, 32'h0000_3004, 32'h2401_0001, held);
    vecs[2]  = mk(0, 1, 0, 0, 0, 32'h0000_3008, 32'h1111_1111, held);
    vecs[3]  = mk(0, 1, 0, 0, 1, 32'h0000_300C, 32'h1111_2222, held);
    vecs[4]  = mk(0, 1, 0, 0, 0, 32'h0000_3020, 32'h1111_3333, held);
    vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0000_3010, 32'h2222_2222, st(32'h3010, 32'h2222_2222, 0, 0, 1));
    vecs[6]  = mk(0, 1, 1, 0, 1, 32'h0000_3014, 32'hAAAA_AAAA, st(32'h4180, 32'h0, 0, 0, 0));
    vecs[7]  = mk(0, 0, 0, 0, 1, 32'h0000_3002, 32'hFFFF_FFFF,
                  st(32'h3002, EXC_ON ? 32'h0 : 32'hFFFF_FFFF, EXC_ON ? 5'd4 : 5'd0, 1, 1));
    vecs[8]  = mk(0, 1, 0, 0, 0, 32'h0000_3008, 32'h5555_0000, vecs[7].exp);
    vecs[9]  = mk(0, 0, 0, 0, 0, 32'h0000_7000, 32'h3333_3333,
                  st(32'h7000, EXC_ON ? 32'h0 : 32'h3333_3333, EXC_ON ? 5'd4 : 5'd0, 0, 1));
    vecs[10] = mk(0, 0, 0, 0, 0, 32'h0000_6FFC, 32'h4444_4444, st(32'h6FFC, 32'h4444_4444, 0, 0, 1));
    vecs[11] = mk(0, 0, 0, 0, 1, 32'h0000_3000, 32'h5555_5555, st(32'h3000, 32'h5555_5555, 0, 1, 1));
    vecs[12] = mk(0, 0, 0, 1, 1, 32'h0000_3018, 32'h6666_6666, st(32'h3018, 32'h0, 0, 0, 0));
    vecs[13] = mk(0, 1, 0, 1, 0, 32'h0000_301C, 32'h6666_7777, st(32'h3018, 32'h0, 0, 0, 0));
    vecs[14] = mk(0, 0, 0, 0, 0, 32'h0000_2FFC, 32'h7777_7777,
                  st(32'h2FFC, EXC_ON ? 32'h0 : 32'h7777_7777, EXC_ON ? 5'd4 : 5'd0, 0, 1));
    vecs[15] = mk(0, 0, 1, 1, 1, 32'h0000_3020, 32'h8888_0000, st(32'h4180, 32'h0, 0, 0, 0));
    vecs[16] = mk(0, 0, 0, 0, 0, 32'h0000_3024, 32'h0000_0088, st(32'h3024, 32'h88, 0, 0, 1));
    vecs[17] = mk(1, 1, 0, 0, 1, 32'h0000_3028, 32'h0000_0099, rst_s);
    vecs[18] = mk(0, 0, 0, 0, 0, 32'h0000_302C, 32'h0000_0099, st(32'h302C, 32'h99, 0, 0, 1));
    vecs[19] = mk(1, 0, 1, 1, 1, 32'h0000_3030, 32'h0000_00AA, rst_s);

    for (int i = 0; i < int'(NVEC); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Multi-cycle: long stall holding a faulting entry, then a flush during stall
    mdl = vecs[NVEC-1].exp;
    begin
      vec_t v;
      v = mk(0, 0, 0, 0, 1, 32'h0000_7004, 32'hDEAD_BEEF, st(0, 0, 0, 0, 0));
      v.exp = model(mdl, v); mdl = v.exp; apply(v, "seq_fault");
      for (int k = 0; k < 4; k++) begin
        v = mk(0, 1, 0, k[0], 0, 32'h0000_3100 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), st(0, 0, 0, 0, 0));
        v.exp = model(mdl, v); mdl = v.exp; apply(v, $sformatf("seq_hold%0d", k));
      end
      v = mk(0, 1, 1, 0, 0, 32'h0000_3200, 32'h1, st(0, 0, 0, 0, 0));
      v.exp = model(mdl, v); mdl = v.exp; apply(v, "seq_flush");
    end

    // Random cycles around the text-segment bounds
    for (int n = 0; n < 300; n++) begin
      vec_t v;
      v.rst   = ($urandom_range(0, 39) == 0);
      v.req   = ($urandom_range(0, 9) == 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.eret  = ($urandom_range(0, 7) == 0);
      v.bj    = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       v.pc = 32'h0000_2FF0 + 32'($urandom_range(0, 32));
        1:       v.pc = 32'h0000_6FF0 + 32'($urandom_range(0, 32));
        2:       v.pc = $urandom;
        default: v.pc = 32'h0000_3000 + 32'($urandom_range(0, 32'h3FFF));
      endcase
      v.instr = $urandom;
      v.exp   = model(mdl, v);
      mdl     = v.exp;
      apply(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
